// File: rtl/calc_spi_pkg.sv
// Shared types and constants for the calculator SPI front-end.
// Register map and opcode values are those understood by the calculator core.
package calc_spi_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RFETCH  = 3'd3,
        ST_RDATA   = 3'd4,
        ST_WAIT_CS = 3'd5
    } spi_state_e;

    // Calculator register map
    localparam logic [6:0] ADDR_OPND   = 7'd1;
    localparam logic [6:0] ADDR_OPCODE = 7'd2;
    localparam logic [6:0] ADDR_RES0   = 7'd4;
    localparam logic [6:0] ADDR_RES1   = 7'd5;
    localparam logic [6:0] ADDR_RES2   = 7'd6;
    localparam logic [6:0] ADDR_RES3   = 7'd7;

    // Calculator operations
    localparam logic [7:0] OPC_ADD = 8'h10;
    localparam logic [7:0] OPC_SUB = 8'h20;
    localparam logic [7:0] OPC_MUL = 8'h30;

    // Saturating 8-bit increment, used by the abort counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulse detection.
// The reset value is a parameter so idle-high lines (cs_n) do not produce a
// spurious edge when reset is released.
module spi_sync_edge
    import calc_spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Next-state: shift the chain and compare the last two samples
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // Synchroniser chain and registered edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register slave for the 4-bit calculator.
// Frame: R/W bit (1=read), address, data, MSB first; mosi sampled on sclk fall,
// miso driven on sclk rise. Optional feature macro: SPI_FRAME_ERR_EN adds
// frame_err / err_cnt reporting of aborted frames.
module spi_reg_slave
    import calc_spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CMD_BITS   = ADDR_W + 1;
    localparam int FRAME_BITS = CMD_BITS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_BITS);
    // Cycles after reset before the cs_n synchroniser output is trustworthy
    localparam logic [3:0]       SETTLE_CNT = 4'(SYNC_STAGES + 1);

    logic sclk_rise_s, sclk_fall_s, unused_sclk_lvl_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .level (unused_sclk_lvl_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .level (cs_lvl_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // mosi gets one stage more than the edge path so it lines up with the
    // registered sclk_fall pulse
    logic [SYNC_STAGES:0] mosi_sync_q, mosi_sync_d;
    assign mosi_s = mosi_sync_q[SYNC_STAGES];

    spi_state_e        state_q, state_d;
    logic              armed_q, armed_d;
    logic [3:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0] cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic              miso_q, miso_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              settled_s;
`ifdef SPI_FRAME_ERR_EN
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    assign settled_s = (settle_q == SETTLE_CNT);

    // Frame FSM next-state: sclk edges drive the shift registers, cs_n rise
    // ends the frame after any same-cycle sclk fall has been applied
    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-1:0], mosi};
        settle_d    = settled_s ? settle_q : (settle_q + 4'd1);
        state_d     = state_q;
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        data_sr_d   = data_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
`ifdef SPI_FRAME_ERR_EN
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_fall_s) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = CNT_ZERO;
                    armed_d   = 1'b0;
                end else begin
                    armed_d = armed_q | (settled_s & cs_lvl_s);
                end
            end
            ST_CMD: begin
                if (sclk_fall_s) begin
                    cmd_sr_d  = {cmd_sr_q[CMD_BITS-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == CMD_LAST) begin
                        if (cmd_sr_d[CMD_BITS-1]) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = cmd_sr_d[ADDR_W-1:0];
                            state_d   = ST_RFETCH;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RFETCH: begin
                // rd_data is valid one clock after the cycle rd_en was high
                if (!rd_en_q) begin
                    tx_sr_d = rd_data;
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_RFETCH;
                end
            end
            ST_RDATA: begin
                if (sclk_rise_s) begin
                    miso_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end else begin
                    tx_sr_d = tx_sr_q;
                end
                if (sclk_fall_s) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    state_d   = (bit_cnt_q == FRAME_LAST) ? ST_WAIT_CS : ST_RDATA;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (sclk_fall_s) begin
                    data_sr_d = {data_sr_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == FRAME_LAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cmd_sr_q[ADDR_W-1:0];
                        wr_data_d = data_sr_d;
                        state_d   = ST_WAIT_CS;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WAIT_CS: begin
                state_d = ST_WAIT_CS;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cs_rise_s) begin
`ifdef SPI_FRAME_ERR_EN
            if ((state_q != ST_IDLE) && (bit_cnt_d != CNT_ZERO) && (bit_cnt_d != FRAME_FULL)) begin
                frame_err_d = 1'b1;
                err_cnt_d   = sat_inc8(err_cnt_q);
            end else begin
                frame_err_d = 1'b0;
            end
`endif
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = CNT_ZERO;
        end else begin
            miso_d = miso_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= {(SYNC_STAGES + 1){1'b0}};
            settle_q    <= 4'd0;
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= CNT_ZERO;
            cmd_sr_q    <= {CMD_BITS{1'b0}};
            data_sr_q   <= {DATA_W{1'b0}};
            tx_sr_q     <= {DATA_W{1'b0}};
            miso_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
`endif
        end else begin
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            data_sr_q   <= data_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign miso    = miso_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed table of frames, a reset
// mid-frame sequence and random frames checked against a frame-level model.
module tb_spi_reg_slave;
    import calc_spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 50;   // sclk half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       miso, wr_en, rd_en, busy;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
    logic [7:0] err_cnt;
    int         ref_err = 0;
`endif

    always #500 clk = ~clk;

    spi_reg_slave #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        exp_wr;
        logic [6:0]  exp_waddr;
        logic [7:0]  exp_wdata;
        logic        exp_rd;
        logic [6:0]  exp_raddr;
        logic [7:0]  exp_miso;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mon_wr = 0, mon_rd = 0, mon_err = 0, mon_wr_cyc = 0;
    logic [7:0] core_mem [int];
    logic [7:0] ref_mem  [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] core_init(input int a);
        logic [7:0] t;
        t = 8'(a);
        if (a == 7) return 8'hA5;
        return t * 8'd29 + 8'd3;
    endfunction

    // Calculator core stand-in and strobe monitor (sampled on falling clk)
    always @(negedge clk) begin
        if (wr_en) begin
            mon_wr++;
            mon_wr_cyc = cyc;
            core_mem[int'(wr_addr)] = wr_data;
        end
        if (rd_en) begin
            mon_rd++;
            rd_data = core_mem.exists(int'(rd_addr)) ? core_mem[int'(rd_addr)] : core_init(int'(rd_addr));
        end
`ifdef SPI_FRAME_ERR_EN
        if (frame_err) mon_err++;
`endif
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [6:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : core_init(int'(a));
    endfunction

    // Frame-level model: what a master sending nb bits of w should cause
    function automatic vec_t model(input logic [15:0] w, input int nb);
        vec_t v;
        int   n;
        n           = (nb > 16) ? 16 : nb;
        v.word      = w;
        v.nbits     = nb;
        v.exp_wr    = (n == 16) && !w[15];
        v.exp_waddr = w[14:8];
        v.exp_wdata = w[7:0];
        v.exp_rd    = (n >= 8) && w[15];
        v.exp_raddr = w[14:8];
        v.exp_miso  = ref_read(w[14:8]);
        v.exp_err   = (n > 0) && (n < 16);
        return v;
    endfunction

    // SPI master: cs_n low, nbits of (rise: drive mosi, fall: sample miso), cs_n high
    task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_bit,
                             output logic [7:0] miso_byte, output logic busy_mid, output int fall16);
        miso_byte = 8'h00;
        busy_mid  = 1'b0;
        fall16    = -1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b0;
            sclk = 1'b1;
            if (i == rst_bit) begin
                repeat (20) @(negedge clk);
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                repeat (HALF - 25) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (i == 0) busy_mid = busy;
            if (i >= 8 && i < 16) miso_byte[15-i] = miso;
            sclk = 1'b0;
            if (i == 15) fall16 = cyc;
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int         w0, r0, e0, f16;
        logic [7:0] mb;
        logic       bm;
        w0 = mon_wr;
        r0 = mon_rd;
        e0 = mon_err;
        spi_frame(v.word, v.nbits, -1, mb, bm, f16);
        chk({nm, ".wr_count"}, mon_wr - w0, {31'd0, v.exp_wr});
        if (v.exp_wr) begin
            chk({nm, ".wr_addr"}, {25'd0, wr_addr}, {25'd0, v.exp_waddr});
            chk({nm, ".wr_data"}, {24'd0, wr_data}, {24'd0, v.exp_wdata});
            chk({nm, ".wr_latency"}, mon_wr_cyc - f16, SYNC + 2);
            ref_mem[int'(v.exp_waddr)] = v.exp_wdata;
        end
        chk({nm, ".rd_count"}, mon_rd - r0, {31'd0, v.exp_rd});
        if (v.exp_rd) chk({nm, ".rd_addr"}, {25'd0, rd_addr}, {25'd0, v.exp_raddr});
        if (v.exp_rd && v.nbits >= 16) chk({nm, ".miso"}, {24'd0, mb}, {24'd0, v.exp_miso});
        chk({nm, ".busy_mid"}, {31'd0, bm}, 32'd1);
        chk({nm, ".busy_end"}, {31'd0, busy}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk({nm, ".frame_err"}, mon_err - e0, {31'd0, v.exp_err});
        if (v.exp_err && ref_err < 255) ref_err++;
        chk({nm, ".err_cnt"}, {24'd0, err_cnt}, ref_err);
`else
        if (e0 != mon_err) chk({nm, ".no_err_port"}, mon_err - e0, 32'd0);
`endif
    endtask

    vec_t       tbl [5];
    vec_t       rv;
    logic [7:0] mb;
    logic       bm;
    int         f16, w0, r0, nb;
    logic [15:0] rw;

    initial begin
        tbl[0] = '{{1'b0, ADDR_OPND, 8'h3C},   16, 1'b1, ADDR_OPND,   8'h3C, 1'b0, 7'd0,      8'h00, 1'b0};
        tbl[1] = '{{1'b1, ADDR_RES3, 8'h00},   16, 1'b0, 7'd0,        8'h00, 1'b1, ADDR_RES3, 8'hA5, 1'b0};
        tbl[2] = '{{1'b0, ADDR_OPND, 8'hFF},   10, 1'b0, 7'd0,        8'h00, 1'b0, 7'd0,      8'h00, 1'b1};
        tbl[3] = '{{1'b0, ADDR_OPCODE, OPC_MUL}, 16, 1'b1, ADDR_OPCODE, OPC_MUL, 1'b0, 7'd0,  8'h00, 1'b0};
        tbl[4] = '{{1'b0, 7'd3, 8'h11},        20, 1'b1, 7'd3,        8'h11, 1'b0, 7'd0,      8'h00, 1'b0};

        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset.miso",    {31'd0, miso},    32'd0);
        chk("reset.wr_en",   {31'd0, wr_en},   32'd0);
        chk("reset.rd_en",   {31'd0, rd_en},   32'd0);
        chk("reset.busy",    {31'd0, busy},    32'd0);
        chk("reset.wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("reset.wr_data", {24'd0, wr_data}, 32'd0);
        chk("reset.rd_addr", {25'd0, rd_addr}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset.err_cnt",   {24'd0, err_cnt},   32'd0);
`endif
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset pulsed during bit 5 with cs_n held low: frame must vanish
        w0 = mon_wr;
        r0 = mon_rd;
        spi_frame({1'b0, ADDR_OPND, 8'h5A}, 16, 4, mb, bm, f16);
        chk("rstmid.wr_count", mon_wr - w0, 32'd0);
        chk("rstmid.rd_count", mon_rd - r0, 32'd0);
        chk("rstmid.busy",     {31'd0, busy},    32'd0);
        chk("rstmid.wr_addr",  {25'd0, wr_addr}, 32'd0);
        chk("rstmid.wr_data",  {24'd0, wr_data}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
        ref_err = 0;
        chk("rstmid.err_cnt",  {24'd0, err_cnt}, 32'd0);
`endif
        run_vec(model({1'b0, ADDR_OPCODE, OPC_ADD}, 16), "after_rst");

        for (int k = 0; k < 14; k++) begin
            rw = {1'(($urandom_range(0, 1))), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 19));
            rv = model(rw, nb);
            run_vec(rv, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
